// File: rtl/fifo_funnel_pkg.sv
// Shared constants and state type for the wide-word to narrow-beat funnel.
package fifo_funnel_pkg;

  localparam int unsigned DefaultWidth     = 128;
  localparam int unsigned DefaultDataWidth = 32;

  typedef enum logic {
    StEmpty = 1'b0,
    StBusy  = 1'b1
  } state_e;

endpackage

// File: rtl/fifo_funnel.sv
// Pops one wide word from an upstream FIFO and streams it downstream as
// width/dataWidth beats, LSB beat first. width must be 2..16 times dataWidth.
module fifo_funnel
  import fifo_funnel_pkg::*;
#(
  parameter int unsigned width     = DefaultWidth,
  parameter int unsigned dataWidth = DefaultDataWidth
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [width-1:0]     in_first,
  input  logic                 in_first__RDY,
  input  logic                 in_deq__RDY,
  output logic                 in_deq__ENA,
  output logic                 out_enq__ENA,
  output logic [dataWidth-1:0] out_enq_v,
  input  logic                 out_enq__RDY
);

  localparam int unsigned N    = width / dataWidth;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  state_e                      state_q, state_d;
  logic   [IdxW-1:0]           idx_q, idx_d;
  logic   [width-1:0]          hold_q, hold_d;
  logic   [N-1:0][dataWidth-1:0] beats;
  logic                        last_beat;

  always_comb begin
    beats     = hold_q;
    out_enq_v = beats[idx_q];
  end

  // Handshakes depend only on state and RDY inputs, never on in_first.
  always_comb begin
    last_beat    = (idx_q == LastIdx);
    out_enq__ENA = (state_q == StBusy) & out_enq__RDY & ~RST;
    in_deq__ENA  = in_deq__RDY & in_first__RDY & ~RST &
                   ((state_q == StEmpty) | ((state_q == StBusy) & last_beat & out_enq__RDY));

    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    if (in_deq__ENA) begin
      // Covers the no-bubble reload when the last beat leaves this cycle.
      state_d = StBusy;
      idx_d   = '0;
      hold_d  = in_first;
    end else if (out_enq__ENA) begin
      if (last_beat) begin
        state_d = StEmpty;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StEmpty;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Hold contents are don't-care after reset, so no reset term here.
  always_ff @(posedge CLK) begin
    hold_q <= hold_d;
  end

endmodule

// File: doc/fifo_funnel.md
FIFO_FUNNEL -- requirements
Module: fifo_funnel

Interface
- REQ-001: Parameter width, default 128, SHALL set the bit width of the word read from the upstream sized FIFO.
- REQ-002: Parameter dataWidth, default 32, SHALL set the output beat width; width SHALL be an integer multiple (2..16) of dataWidth.
- REQ-003: Port CLK, input, 1, SHALL be the single clock.
- REQ-004: Port RST, input, 1, SHALL be the reset: synchronous, active-high.
- REQ-005: Port in$first, input, width, SHALL carry the upstream FIFO head word.
- REQ-006: Port in$first__RDY, input, 1, SHALL indicate in$first is valid.
- REQ-007: Port in$deq__RDY, input, 1, SHALL indicate upstream deq is permitted.
- REQ-008: Port in$deq__ENA, output, 1, SHALL pop the upstream head word.
- REQ-009: Port out$enq__ENA, output, 1, SHALL present one beat downstream.
- REQ-010: Port out$enq$v, output, dataWidth, SHALL carry the current beat.
- REQ-011: Port out$enq__RDY, input, 1, SHALL indicate downstream accepts a beat.

Function
- REQ-012: Beat count SHALL be N = width/dataWidth; beat index register idx SHALL be clog2(N) bits and wrap N-1 -> 0.
- REQ-013: States SHALL be EMPTY (no word held) and BUSY (word held in hold register, idx = next beat).
- REQ-014: in$deq__ENA SHALL equal in$deq__RDY & in$first__RDY & (EMPTY | (BUSY & idx==N-1 & out$enq__RDY)).
- REQ-015: On in$deq__ENA the hold register SHALL load in$first, idx SHALL become 0, state SHALL become BUSY, at the next edge.
- REQ-016: Latency: first beat of a word popped at cycle t SHALL be offered at cycle t+1.
- REQ-017: out$enq__ENA SHALL equal BUSY & out$enq__RDY; never asserted when out$enq__RDY is low.
- REQ-018: out$enq$v SHALL be hold[idx*dataWidth +: dataWidth] (beat 0 = LSBs first); value when ENA low is don't-care but SHALL be stable while BUSY and stalled.
- REQ-019: On out$enq__ENA with idx<N-1, idx SHALL increment by 1.
- REQ-020: On out$enq__ENA with idx==N-1 and no simultaneous deq, state SHALL become EMPTY.
- REQ-021: Simultaneous last-beat send and deq SHALL reload without bubble: N beats per N cycles sustained.
- REQ-022: Downstream stall (out$enq__RDY low) SHALL freeze idx, hold register and state.
- REQ-023: Upstream empty (in$first__RDY low) in EMPTY SHALL keep state EMPTY with no outputs asserted.
- REQ-024: in$deq__ENA and out$enq__ENA SHALL be combinationally dependent only on inputs and registered state (no loop through in$first).

Reset
- REQ-025: With RST high at a CLK edge, state SHALL become EMPTY, idx 0; hold register contents SHALL be don't-care.
- REQ-026: While RST is high, in$deq__ENA and out$enq__ENA SHALL be 0.
- REQ-027: Reset mid-word SHALL discard remaining beats; no partial word resumes after reset.

Structure
- REQ-028: Shared package SHALL hold the default width/dataWidth constants and the state enum (EMPTY, BUSY).
- REQ-029: No sub-module is required; beat selection SHALL be inline.

Verification
- REQ-030: Word 0x4444_4444_3333_3333_2222_2222_1111_1111, RDY always high -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting t+1.
- REQ-031: 3 back-to-back words, out$enq__RDY high -> 12 beats in 12 consecutive cycles; in$deq__ENA pulses on cycles 0, 4, 8.
- REQ-032: out$enq__RDY low for 5 cycles after beat 1 -> out$enq$v holds 0x22222222, idx frozen, no deq; resumes at beat 2.
- REQ-033: Upstream empty after one word -> 4 beats, then state EMPTY, all ENAs 0 until in$first__RDY rises.
- REQ-034: RST asserted after beat 1 -> next cycle no ENA; after release a new word starts at beat 0.
- REQ-035: width=64, dataWidth=16, word 0xDDDDCCCCBBBBAAAA -> beats 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD.
